ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch unit that replaces the combinational instruction-memory read ahead of the decode stage. It owns the architectural PC and issues a request/response fetch to instruction memory over a valid/ready bus, then presents {pc, inst} to decode with a valid/ready handshake. It accepts the next PC (dnpc) from the execute stage before starting the following fetch, giving a multi-cycle, non-pipelined fetch loop with a bus-timeout guard.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
TIMEOUT_CYCLES, 255, max cycles waiting for a read response; 0 disables the timeout

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low
dnpc  in  32  next PC from execute
npc_valid  in  1  dnpc valid
npc_ready  out  1  IFU accepts dnpc
imem_arvalid  out  1  read request valid
imem_araddr  out  32  read address (= pc register)
imem_arready  in  1  memory accepts request
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
imem_rresp  in  2  response code; 2'b00 = OKAY
imem_rready  out  1  IFU accepts read data
inst_valid  out  1  instruction valid to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  fetched instruction
pc  out  32  PC of inst
fetch_err  out  1  fetch fault for this inst (bus error or timeout)

Behaviour:
- Reset (rst=0, async): state=S_ADDR, pc=RESET_PC, inst=0, fetch_err=0, drain=0, timeout counter=0. While in reset, all valid/ready outputs are 0.
- FSM states:
  - S_ADDR: arvalid=1, araddr=pc. On arvalid&&arready, go to S_DATA and clear the counter.
  - S_DATA: rready=1. On rvalid:
    - latch inst=rdata and fetch_err=0 if rresp==0;
    - otherwise latch inst=0 and fetch_err=1;
    - go to S_OUT.
    - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: inst=0, fetch_err=1, drain=1, go to S_OUT. Else counter+1.
  - S_OUT: inst_valid=1. On inst_ready, go to S_NPC.
  - S_NPC: npc_ready=1 only when drain==0. On npc_valid&&npc_ready, pc<=dnpc and go to S_ADDR.
- arvalid/araddr are held stable until arready. inst/pc/fetch_err are held stable while inst_valid&&!inst_ready.
- Response timing:
  - rvalid is only sampled in S_DATA.
  - A response in the same cycle as the arready handshake is not accepted; memory returns data at the earliest one cycle later.
- Drain: while drain=1 and state!=S_DATA, rready=1. A late rvalid is discarded and clears drain. A new request is never issued while drain=1.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and the counter saturates. dnpc is taken as-is; bits [1:0] are ignored unless the optional feature is enabled.
- Reset mid-operation aborts any outstanding transaction immediately. Memory must tolerate the dropped request.
- Steady throughput with zero-wait memory and always-ready neighbours: one instruction per 4 cycles.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: on the npc handshake, if dnpc[1:0]!=0, pc<=dnpc but S_ADDR is skipped. The FSM goes directly to S_OUT with inst=0, fetch_err=1, and no bus request. Same check applies to RESET_PC at reset.
- Undefined: no check; araddr=dnpc verbatim.

Decomposition:
- Package ifu_pkg: state enum (S_ADDR, S_DATA, S_OUT, S_NPC), RESP_OKAY=2'b00, INST_FAULT=32'h0, XLEN=32.
- One sub-module: ifu_timeout_ctr (clear/enable/expire, parameterised by TIMEOUT_CYCLES).

Test Plan:
- Release rst -> first cycle: arvalid=1, araddr=0x8000_0000. Hold arready=0 for 3 cycles -> araddr stable, arvalid held.
- Zero-wait memory with rdata=0x0010_0093 and inst_ready=1 -> inst_valid with inst=0x0010_0093, pc=0x8000_0000, fetch_err=0. dnpc=0x8000_0004 -> next araddr=0x8000_0004 at 4-cycle cadence.
- inst_ready=0 for 5 cycles -> inst, pc, inst_valid unchanged. npc_ready stays 0 until the handshake completes.
- rresp=2'b10 with rdata=0xdead_beef -> inst=0, fetch_err=1.
- TIMEOUT_CYCLES=8, no rvalid -> inst_valid after 8 S_DATA cycles with fetch_err=1. Late rvalid 4 cycles later is drained; npc_ready=0 until it arrives.
- Assert rst in S_DATA -> all outputs reset asynchronously. With IFU_MISALIGN_CHECK_EN, dnpc=0x8000_0002 -> no arvalid, inst_valid with fetch_err=1, pc=0x8000_0002.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit (ifu_fetch and its timeout counter).
// Optional build macro IFU_MISALIGN_CHECK_EN enables the PC alignment check in ifu_fetch.
package ifu_pkg;

    localparam int              XLEN       = 32;
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [XLEN-1:0] INST_FAULT = 32'h0;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DATA = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } ifu_state_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Saturating wait counter for the read-response phase; expire flags the last allowed cycle.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module ifu_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] MAX  = '1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch loop: request -> response -> present to decode -> accept next PC.
// Optional build macro IFU_MISALIGN_CHECK_EN faults misaligned PCs without touching the bus.
//
// Handshakes: every channel (imem AR, imem R, inst, npc) transfers on a rising clk edge where
// valid && ready are both high; a source holds valid and its payload stable until that edge.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dnpc,
    input  logic        npc_valid,
    output logic        npc_ready,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic RESET_MISALIGNED = (RESET_PC[1:0] != 2'b00);
    logic w_misalign;
    assign w_misalign = is_misaligned(dnpc);
`else
    localparam logic RESET_MISALIGNED = 1'b0;
    logic w_misalign;
    assign w_misalign = 1'b0;
`endif

    localparam ifu_state_e RESET_STATE = RESET_MISALIGNED ? S_OUT : S_ADDR;

    ifu_state_e        r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic              r_err;
    logic              r_drain;

    logic w_arvalid;
    logic w_rready;
    logic w_npc_ready;
    logic w_inst_valid;
    logic w_ar_hs;
    logic w_expire;

    // Handshake outputs are pure decodes of the state registers, forced low while reset is held.
    assign w_arvalid    = (r_state == S_ADDR) && !r_drain;
    assign w_rready     = (r_state == S_DATA) || r_drain;
    assign w_npc_ready  = (r_state == S_NPC) && !r_drain;
    assign w_inst_valid = (r_state == S_OUT);
    assign w_ar_hs      = w_arvalid && imem_arready;

    ifu_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (w_ar_hs),
        .enable((r_state == S_DATA) && !imem_rvalid),
        .expire(w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RESET_STATE;
            r_pc    <= RESET_PC;
            r_inst  <= INST_FAULT;
            r_err   <= RESET_MISALIGNED;
            r_drain <= 1'b0;
        end else begin
            // A response that arrives after a timeout is swallowed here, never in S_DATA.
            if (r_drain && (r_state != S_DATA) && imem_rvalid) begin
                r_drain <= 1'b0;
            end
            case (r_state)
                S_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (imem_rvalid) begin
                        r_inst  <= (imem_rresp == RESP_OKAY) ? imem_rdata : INST_FAULT;
                        r_err   <= (imem_rresp != RESP_OKAY);
                        r_state <= S_OUT;
                    end else if (w_expire) begin
                        r_inst  <= INST_FAULT;
                        r_err   <= 1'b1;
                        r_drain <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        r_state <= S_NPC;
                    end
                end
                S_NPC: begin
                    if (npc_valid && w_npc_ready) begin
                        r_pc <= dnpc;
                        if (w_misalign) begin
                            r_inst  <= INST_FAULT;
                            r_err   <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                default: r_state <= S_ADDR;
            endcase
        end
    end

    assign imem_arvalid = rst && w_arvalid;
    assign imem_rready  = rst && w_rready;
    assign npc_ready    = rst && w_npc_ready;
    assign inst_valid   = rst && w_inst_valid;
    assign imem_araddr  = r_pc;
    assign pc           = r_pc;
    assign inst         = r_inst;
    assign fetch_err    = r_err;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized tail, scoreboarded.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TO     = 8;

  logic        clk;
  logic        rst;
  logic [31:0] dnpc;
  logic        npc_valid;
  logic        npc_ready;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [31:0] cur_pc;
  logic [64:0] exp_q[$];

  ifu_fetch #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dnpc        (dnpc),
    .npc_valid   (npc_valid),
    .npc_ready   (npc_ready),
    .imem_arvalid(imem_arvalid),
    .imem_araddr (imem_araddr),
    .imem_arready(imem_arready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rresp  (imem_rresp),
    .imem_rready (imem_rready),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // scoreboard: compare each accepted instruction against the queued expectation
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got err=%0b pc=%h inst=%h, expected nothing", fetch_err, pc, inst);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({fetch_err, pc, inst} !== e) begin
          n_fail++;
          $display("FAIL sb_inst: got err=%0b pc=%h inst=%h, expected err=%0b pc=%h inst=%h",
                   fetch_err, pc, inst, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full fetch loop with optional AR and decode back-pressure
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input int ar_wait, input int inst_wait, input logic [31:0] next_pc);
    int          guard;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    guard = 0;
    while (!imem_arvalid && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (imem_arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL arvalid_wait: arvalid=%b, expected 1 within 20 cycles", imem_arvalid);
    end
    n_checks++;
    if (imem_araddr !== addr) begin
      n_fail++;
      $display("FAIL araddr: got %h, expected %h", imem_araddr, addr);
    end
    for (int i = 0; i < ar_wait; i++) begin
      imem_arready = 1'b0;
      tick();
      n_checks++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== addr) begin
        n_fail++;
        $display("FAIL ar_hold: arvalid=%b araddr=%h, expected 1 %h", imem_arvalid, imem_araddr, addr);
      end
    end
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    n_checks++;
    if (imem_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL rready: got %b, expected 1", imem_rready);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    imem_rresp  = resp;
    exp_q.push_back({resp != 2'b00, addr, (resp == 2'b00) ? data : 32'h0});
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL inst_valid: got %b, expected 1", inst_valid);
    end
    s_pc   = pc;
    s_inst = inst;
    for (int i = 0; i < inst_wait; i++) begin
      inst_ready = 1'b0;
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || pc !== s_pc || inst !== s_inst || npc_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL inst_hold: valid=%b pc=%h inst=%h npc_ready=%b, expected 1 %h %h 0",
                 inst_valid, pc, inst, npc_ready, s_pc, s_inst);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_checks++;
    if (npc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL npc_ready: got %b, expected 1", npc_ready);
    end
    npc_valid = 1'b1;
    dnpc      = next_pc;
    tick();
    npc_valid = 1'b0;
    cur_pc    = next_pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({imem_arvalid, imem_rready, inst_valid, npc_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b, expected 0000",
               {imem_arvalid, imem_rready, inst_valid, npc_ready});
    end
    n_checks++;
    if (pc !== RST_PC || inst !== 32'h0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h inst=%h err=%b, expected %h 0 0", pc, inst, fetch_err, RST_PC);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== RST_PC || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: arvalid=%b araddr=%h state=%0d, expected 1 %h 0",
               imem_arvalid, imem_araddr, dbg_state, RST_PC);
    end
    cur_pc = RST_PC;
  endtask

  task automatic test_basic();
    do_fetch(RST_PC, 32'h0010_0093, 2'b00, 3, 0, 32'h8000_0004);
  endtask

  task automatic test_cadence();
    int t0;
    t0 = cyc;
    do_fetch(cur_pc, 32'h0020_0113, 2'b00, 0, 0, 32'h8000_0008);
    n_checks++;
    if (cyc - t0 !== 4 || imem_arvalid !== 1'b1 || imem_araddr !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL cadence: cycles=%0d arvalid=%b araddr=%h, expected 4 1 80000008",
               cyc - t0, imem_arvalid, imem_araddr);
    end
  endtask

  task automatic test_stall();
    do_fetch(cur_pc, 32'h1234_5678, 2'b00, 0, 5, 32'h8000_000c);
  endtask

  task automatic test_bus_error();
    do_fetch(cur_pc, 32'hdead_beef, 2'b10, 0, 0, 32'h8000_0010);
  endtask

  task automatic test_same_cycle_resp();
    n_checks++;
    if (imem_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_rready: got %b, expected 0", imem_rready);
    end
    imem_arready = 1'b1;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'hbad0_bad0;
    imem_rresp   = 2'b00;
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0040_0213;
    exp_q.push_back({1'b0, cur_pc, 32'h0040_0213});
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0040_0213) begin
      n_fail++;
      $display("FAIL same_cycle_resp: valid=%b inst=%h, expected 1 00400213", inst_valid, inst);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b1;
    dnpc       = 32'h8000_0014;
    tick();
    npc_valid = 1'b0;
    cur_pc    = 32'h8000_0014;
  endtask

  task automatic test_timeout();
    int n;
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    exp_q.push_back({1'b1, cur_pc, 32'h0});
    n = 0;
    while (!inst_valid && n < 20) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== TO || inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout: wait=%0d valid=%b err=%b inst=%h, expected %0d 1 1 0",
               n, inst_valid, fetch_err, inst, TO);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b1;
    dnpc       = 32'h8000_0018;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (npc_ready !== 1'b0 || imem_rready !== 1'b1 || imem_arvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_hold: npc_ready=%b rready=%b arvalid=%b, expected 0 1 0",
                 npc_ready, imem_rready, imem_arvalid);
      end
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hface_face;
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (npc_ready !== 1'b1 || imem_rready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_clear: npc_ready=%b rready=%b, expected 1 0", npc_ready, imem_rready);
    end
    tick();
    npc_valid = 1'b0;
    cur_pc    = 32'h8000_0018;
    n_checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== cur_pc) begin
      n_fail++;
      $display("FAIL after_drain: arvalid=%b araddr=%h, expected 1 %h", imem_arvalid, imem_araddr, cur_pc);
    end
  endtask

`ifdef IFU_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_fetch(cur_pc, 32'h0050_0293, 2'b00, 0, 0, 32'h8000_0102);
    exp_q.push_back({1'b1, 32'h8000_0102, 32'h0});
    n_checks++;
    if (imem_arvalid !== 1'b0 || inst_valid !== 1'b1 || fetch_err !== 1'b1 ||
        pc !== 32'h8000_0102 || inst !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign: arvalid=%b valid=%b err=%b pc=%h inst=%h, expected 0 1 1 80000102 0",
               imem_arvalid, inst_valid, fetch_err, pc, inst);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    npc_valid  = 1'b1;
    dnpc       = 32'h8000_0200;
    tick();
    npc_valid = 1'b0;
    cur_pc    = 32'h8000_0200;
  endtask
`endif

  task automatic test_random();
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] next;
    for (int k = 0; k < 8; k++) begin
      data = $urandom;
      resp = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      next = cur_pc + 32'($urandom_range(1, 8) * 4);
      do_fetch(cur_pc, data, resp, $urandom_range(0, 2), $urandom_range(0, 2), next);
    end
  endtask

  task automatic test_reset_mid();
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd1 || pc === RST_PC) begin
      n_fail++;
      $display("FAIL mid_setup: state=%0d pc=%h, expected 1 and pc != %h", dbg_state, pc, RST_PC);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_arvalid, imem_rready, inst_valid, npc_ready} !== 4'b0000 || pc !== RST_PC ||
        inst !== 32'h0 || fetch_err !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: hs=%b pc=%h inst=%h err=%b state=%0d, expected 0000 %h 0 0 0",
               {imem_arvalid, imem_rready, inst_valid, npc_ready}, pc, inst, fetch_err, dbg_state, RST_PC);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_arvalid !== 1'b1 || imem_araddr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_restart: arvalid=%b araddr=%h, expected 1 %h", imem_arvalid, imem_araddr, RST_PC);
    end
    cur_pc = RST_PC;
    do_fetch(cur_pc, 32'h0060_0313, 2'b00, 0, 0, 32'h8000_0004);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    dnpc         = 32'h0;
    npc_valid    = 1'b0;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
    inst_ready   = 1'b0;
    cur_pc       = RST_PC;

    test_reset();
    test_basic();
    test_cadence();
    test_stall();
    test_bus_error();
    test_same_cycle_resp();
    test_timeout();
`ifdef IFU_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    test_reset_mid();

    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
